md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit_pkg.sv | 78 +++++++
 rtl/md_calc.sv | 81 ++++++++
 rtl/md_unit.sv | 144 ++++++++++++++
 tb/tb_md_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// md_unit shared constants: MD_op encodings and op-class helpers.
// MD_UNIT_MADD_EN enables the MADD/MADDU/MSUB/MSUBU group.
package md_unit_pkg;

  localparam int CNT_W = 5;

`ifdef MD_UNIT_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11,
    MD_MSUBU = 4'd12
  } md_op_e;

  function automatic logic md_is_acc(
    input logic [3:0] op
  );
    return MADD_EN &&
      (op inside {MD_MADD, MD_MADDU,
                  MD_MSUB, MD_MSUBU});
  endfunction

  function automatic logic md_is_mul(
    input logic [3:0] op
  );
    return op inside {MD_MULT, MD_MULTU};
  endfunction

  function automatic logic md_is_div(
    input logic [3:0] op
  );
    return op inside {MD_DIV, MD_DIVU};
  endfunction

  function automatic logic md_is_run(
    input logic [3:0] op
  );
    return md_is_mul(op) | md_is_div(op) |
      md_is_acc(op);
  endfunction

  function automatic logic md_is_signed(
    input logic [3:0] op
  );
    return op inside {MD_MULT, MD_DIV,
                      MD_MADD, MD_MSUB};
  endfunction

  function automatic logic md_is_sub(
    input logic [3:0] op
  );
    return op inside {MD_MSUB, MD_MSUBU};
  endfunction

  // Codes that must hold decode while presented.
  function automatic logic md_is_class(
    input logic [3:0] op
  );
    return md_is_run(op) |
      (op inside {MD_MTHI, MD_MTLO,
                  MD_MFHI, MD_MFLO});
  endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational product/quotient/remainder for md_unit.
// MD_UNIT_MADD_EN adds the {HI,LO} accumulate path.
module md_calc
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);

  localparam int W2 = 2 * WIDTH;

  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic             div_ok;
  logic             div_z;
  logic             mul_op;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [W2-1:0]    p_mag;
  logic [W2-1:0]    prod;

  // Signed ops work on magnitudes; signs reapplied after.
  assign sgn    = md_is_signed(op);
  assign a_neg  = sgn & a[WIDTH-1];
  assign b_neg  = sgn & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign b_zero = (b == '0);

  assign p_mag = {{WIDTH{1'b0}}, a_mag} *
                 {{WIDTH{1'b0}}, b_mag};
  assign prod  = (a_neg ^ b_neg) ? -p_mag : p_mag;

  // MIN / -1 wraps to MIN naturally via the magnitude path.
  assign q_mag = b_zero ? '0 : a_mag / b_mag;
  assign r_mag = b_zero ? '0 : a_mag % b_mag;
  assign quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem   = a_neg ? -r_mag : r_mag;

  assign div_ok = md_is_div(op) & ~b_zero;
  assign div_z  = md_is_div(op) & b_zero;
  assign mul_op = md_is_mul(op);

`ifdef MD_UNIT_MADD_EN
  logic          acc_op;
  logic [W2-1:0] acc;

  assign acc_op = md_is_acc(op);
  assign acc    = md_is_sub(op) ?
                  {hi, lo} - prod :
                  {hi, lo} + prod;
`endif

  // Select the {HI,LO} result for the latched op.
  always_comb begin
    {hi_n, lo_n} = {hi, lo};
    unique case (1'b1)
      div_ok:  {hi_n, lo_n} = {rem, quo};
      div_z:   {hi_n, lo_n} = {hi, lo};
      mul_op:  {hi_n, lo_n} = prod;
`ifdef MD_UNIT_MADD_EN
      acc_op:  {hi_n, lo_n} = acc;
`endif
      default: {hi_n, lo_n} = {hi, lo};
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
// MD_UNIT_MADD_EN enables the multiply-accumulate ops.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [3:0]       MD_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] MC =
    CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DC =
    CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);

  state_e           state;
  state_e           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             load;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;
  logic [WIDTH-1:0] c_hi;
  logic [WIDTH-1:0] c_lo;

  md_calc #(
    .WIDTH(WIDTH)
  ) u_calc (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .hi   (hi_q),
    .lo   (lo_q),
    .hi_n (c_hi),
    .lo_n (c_lo)
  );

  assign busy  = (state == RUN);
  assign stall = busy |
                 (start & md_is_class(MD_op));
  assign HI    = hi_q;
  assign LO    = lo_q;

  // FSM state and busy counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state, counter and HI/LO update; flush wins.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    hi_n    = hi_q;
    lo_n    = lo_q;
    unique case (state)
      IDLE: begin
        if (start && !flush) begin
          if (md_is_run(MD_op)) begin
            state_n = RUN;
            load    = 1'b1;
            cnt_n   = md_is_div(MD_op) ? DC : MC;
          end else if (MD_op == MD_MTHI) begin
            hi_n = A;
          end else if (MD_op == MD_MTLO) begin
            lo_n = A;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == ONE) begin
          state_n = IDLE;
          cnt_n   = '0;
          hi_n    = c_hi;
          lo_n    = c_lo;
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Operand latch for the op in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (load) begin
      op_q <= MD_op;
      a_q  <= A;
      b_q  <= B;
    end
  end

  // HI/LO architectural registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_n;
      lo_q <= lo_n;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed bench for md_unit with a cycle-level
// reference model and per-cycle compare of busy/stall/HI/LO.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  MD_op = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

`ifdef MD_UNIT_MADD_EN
  localparam bit TB_MADD = 1'b1;
`else
  localparam bit TB_MADD = 1'b0;
`endif

  md_unit #(
    .WIDTH(32),
    .MULT_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .flush (flush),
    .MD_op (MD_op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .stall (stall),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Architectural result of an op, from plain arithmetic.
  function automatic logic [63:0] model_res(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] hi,
    input logic [31:0] lo
  );
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: return 64'(sa * sb);
      4'd2: return {32'd0, a} * {32'd0, b};
      4'd3: begin
        if (b == 32'd0) return {hi, lo};
        if (a == 32'h8000_0000 &&
            b == 32'hFFFF_FFFF)
          return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
      4'd9, 4'd10, 4'd11, 4'd12: begin
        if (op == 4'd9 || op == 4'd11)
          p = 64'(sa * sb);
        else
          p = {32'd0, a} * {32'd0, b};
        if (op >= 4'd11) return {hi, lo} - p;
        return {hi, lo} + p;
      end
      default: return {hi, lo};
    endcase
  endfunction

  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_left;

  // Reference model: remaining busy cycles and pending result.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_left <= 0;
      m_pend <= 64'd0;
    end else if (m_left > 0) begin
      if (flush) begin
        m_left <= 0;
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= m_pend[63:32];
          m_lo <= m_pend[31:0];
        end
      end
    end else if (start && !flush) begin
      case (MD_op)
        4'd1, 4'd2: begin
          m_pend <= model_res(MD_op, A, B, m_hi, m_lo);
          m_left <= 5;
        end
        4'd3, 4'd4: begin
          m_pend <= model_res(MD_op, A, B, m_hi, m_lo);
          m_left <= 10;
        end
        4'd9, 4'd10, 4'd11, 4'd12: begin
          if (TB_MADD) begin
            m_pend <= model_res(MD_op, A, B,
                                m_hi, m_lo);
            m_left <= 5;
          end
        end
        4'd5: m_hi <= A;
        4'd6: m_lo <= A;
        default: ;
      endcase
    end
  end

  function automatic logic exp_stall();
    logic cls;
    cls = (MD_op >= 4'd1 && MD_op <= 4'd8) ||
          (TB_MADD && MD_op >= 4'd9 &&
           MD_op <= 4'd12);
    return (m_left > 0) || (start && cls);
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", 32'(busy), 32'(m_left > 0));
      check("stall", 32'(stall), 32'(exp_stall()));
      check("HI", HI, m_hi);
      check("LO", LO, m_lo);
    end
  end

  task automatic issue(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(posedge clk);
    #1;
    start = 1'b1;
    MD_op = op;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    MD_op = 4'd0;
  endtask

  task automatic count_busy(output int n);
    bit done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (busy) n++;
      else done = 1'b1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL busy_timeout: got busy want idle");
    end
  endtask

  int          n;
  logic [31:0] e_n, e_hi, e_lo;

  initial begin
    @(negedge clk);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset  = 1'b0;
    chk_on = 1'b1;

    issue(MD_MULT, 32'hFFFF_FFFF, 32'd2);
    count_busy(n);
    check("mult_cyc", 32'(n), 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFE);

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    count_busy(n);
    check("multu_hi", HI, 32'd1);
    check("multu_lo", LO, 32'hFFFF_FFFE);

    issue(MD_DIV, -32'sd7, 32'd2);
    count_busy(n);
    check("div_cyc", 32'(n), 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    issue(MD_DIVU, 32'd7, 32'd2);
    count_busy(n);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);

    issue(MD_MTHI, 32'h11, 32'd0);
    issue(MD_MTLO, 32'h22, 32'd0);
    issue(MD_DIV, 32'h99, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b1;
    MD_op = MD_MULTU;
    A     = 32'd3;
    B     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    MD_op = 4'd0;
    count_busy(n);
    check("div0_rest", 32'(n), 32'd8);
    check("div0_hi", HI, 32'h11);
    check("div0_lo", LO, 32'h22);
    repeat (3) @(negedge clk);
    check("div0_nostart", 32'(busy), 32'd0);

    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    check("ovf_lo", LO, 32'h8000_0000);
    check("ovf_hi", HI, 32'd0);

    issue(MD_MULT, 32'd3, 32'd4);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_hi", HI, 32'd0);
    check("flush_lo", LO, 32'h8000_0000);

    @(posedge clk);
    #1;
    start = 1'b1;
    flush = 1'b1;
    MD_op = MD_MULT;
    A     = 32'd9;
    B     = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    MD_op = 4'd0;
    @(negedge clk);
    check("flstart_busy", 32'(busy), 32'd0);

    issue(MD_MTHI, 32'h5A, 32'd0);
    issue(MD_MULT, 32'd5, 32'd5);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rstrun_hi", HI, 32'd0);
    check("rstrun_lo", LO, 32'd0);
    check("rstrun_busy", 32'(busy), 32'd0);
    #1;
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("rstrun_nowr", LO, 32'd0);

    issue(MD_MTLO, 32'h1234, 32'd0);
    check("mtlo_lo", LO, 32'h1234);
    check("mtlo_busy", 32'(busy), 32'd0);

    @(posedge clk);
    #1;
    start = 1'b1;
    MD_op = MD_MULT;
    A     = 32'd2;
    B     = 32'd3;
    #2;
    check("start_stall", 32'(stall), 32'd1);
    check("start_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    MD_op = 4'd0;
    count_busy(n);
    check("m23_lo", LO, 32'd6);

    issue(4'd13, 32'hDEAD, 32'd1);
    issue(MD_NONE, 32'hBEEF, 32'd1);
    issue(MD_MFHI, 32'h77, 32'd1);
    @(negedge clk);
    check("nop_lo", LO, 32'd6);
    check("nop_busy", 32'(busy), 32'd0);

    issue(MD_MTHI, 32'd0, 32'd0);
    issue(MD_MTLO, 32'hFFFF_FFFF, 32'd0);
    issue(MD_MADDU, 32'd1, 32'd1);
    count_busy(n);
`ifdef MD_UNIT_MADD_EN
    e_n  = 32'd5;
    e_hi = 32'd1;
    e_lo = 32'd0;
`else
    e_n  = 32'd0;
    e_hi = 32'd0;
    e_lo = 32'hFFFF_FFFF;
`endif
    check("madd_cyc", 32'(n), e_n);
    check("madd_hi", HI, e_hi);
    check("madd_lo", LO, e_lo);

    repeat (2) @(negedge clk);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
